classifier_seq_ctrl: RTL and testbench

CLASSIFIER_SEQ_CTRL -- requirements
Module: classifier_seq_ctrl

---
 rtl/classifier_seq_ctrl.sv | 136 +++++++++++++
 tb/tb_classifier_seq_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/classifier_seq_ctrl.sv
// Sequencing controller around a combinational classifier: collects feature beats,
// waits a fixed settle window, captures the result and hands it downstream.
module classifier_seq_ctrl #(
    parameter int unsigned NUM_A         = 9,
    parameter int unsigned WIDTH_A       = 4,
    parameter int unsigned OUTWIDTH      = 22,
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic [WIDTH_A-1:0]         s_data,
    input  logic                       s_last,
    output logic [NUM_A*WIDTH_A-1:0]   clf_inp,
    input  logic [OUTWIDTH-1:0]        clf_out,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [OUTWIDTH-1:0]        m_data,
    output logic                       busy,
    output logic                       err_frame,
    output logic [15:0]                sample_cnt
);

    localparam int unsigned IDX_W = (NUM_A > 1) ? $clog2(NUM_A) : 1;
    localparam int unsigned CNT_W = 8;
    localparam int unsigned IN_W  = NUM_A * WIDTH_A;
    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_A - 1);
    localparam logic [CNT_W-1:0] SETTLE_INIT = CNT_W'(SETTLE_CYCLES);

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [IDX_W-1:0]   r_idx;
    logic [CNT_W-1:0]   r_settle;
    logic [IN_W-1:0]    r_clf_inp;
    logic [OUTWIDTH-1:0] r_m_data;
    logic               r_m_valid;
    logic               r_s_ready;
    logic               r_busy;
    logic               r_err_frame;
    logic [15:0]        r_sample_cnt;

    logic w_accept;
    logic w_is_last_idx;
    logic w_early_last;
    logic w_done;
    logic w_capture;
    logic w_handshake;

    assign w_accept      = s_valid && r_s_ready && (r_state == ST_LOAD);
    assign w_is_last_idx = (r_idx == LAST_IDX);
    assign w_early_last  = w_accept && s_last && !w_is_last_idx;
    assign w_done        = w_accept && w_is_last_idx;
    // Counter runs SETTLE_CYCLES down to 0; the capture edge follows the zero cycle.
    assign w_capture     = (r_state == ST_SETTLE) && (r_settle == '0);
    assign w_handshake   = (r_state == ST_HOLD) && r_m_valid && m_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_LOAD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_LOAD:   if (w_done)      w_state_nxt = ST_SETTLE;
            ST_SETTLE: if (w_capture)   w_state_nxt = ST_HOLD;
            ST_HOLD:   if (w_handshake) w_state_nxt = ST_LOAD;
            default:                    w_state_nxt = ST_LOAD;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx        <= '0;
            r_settle     <= '0;
            r_clf_inp    <= '0;
            r_m_data     <= '0;
            r_m_valid    <= 1'b0;
            r_s_ready    <= 1'b0;
            r_busy       <= 1'b0;
            r_err_frame  <= 1'b0;
            r_sample_cnt <= '0;
        end else begin
            r_s_ready <= (w_state_nxt == ST_LOAD);
            r_busy    <= (w_state_nxt != ST_LOAD);

            if (r_state != ST_LOAD) begin
                r_idx <= '0;
            end else if (w_accept) begin
                r_idx <= (w_early_last || w_is_last_idx) ? '0 : r_idx + IDX_W'(1);
            end

            // A beat that closes a frame early is dropped, not written.
            if (w_accept && !w_early_last) begin
                r_clf_inp[32'(r_idx) * WIDTH_A +: WIDTH_A] <= s_data;
            end

            if (w_done) begin
                r_settle <= SETTLE_INIT;
            end else if ((r_state == ST_SETTLE) && (r_settle != '0)) begin
                r_settle <= r_settle - CNT_W'(1);
            end

            if (w_capture) begin
                r_m_data  <= clf_out;
                r_m_valid <= 1'b1;
            end else if (w_handshake) begin
                r_m_valid    <= 1'b0;
                r_sample_cnt <= r_sample_cnt + 16'd1;
            end

            if (w_early_last || (w_done && !s_last)) begin
                r_err_frame <= 1'b1;
            end
        end
    end

    assign s_ready    = r_s_ready;
    assign clf_inp    = r_clf_inp;
    assign m_valid    = r_m_valid;
    assign m_data     = r_m_data;
    assign busy       = r_busy;
    assign err_frame  = r_err_frame;
    assign sample_cnt = r_sample_cnt;

endmodule

// File: tb/tb_classifier_seq_ctrl.sv
// Bench for classifier_seq_ctrl: directed scenarios plus random traffic, all
// outputs compared every cycle against a timestamp/array model of the controller.
module tb_classifier_seq_ctrl;

    localparam int NUM_A    = 9;
    localparam int WIDTH_A  = 4;
    localparam int OUTWIDTH = 22;
    localparam int SETTLE   = 4;
    localparam int IN_W     = NUM_A * WIDTH_A;

    logic                clk = 1'b0;
    logic                rst;
    logic                s_valid, s_ready, s_last;
    logic [WIDTH_A-1:0]  s_data;
    logic [IN_W-1:0]     clf_inp;
    logic [OUTWIDTH-1:0] clf_out;
    logic                m_valid, m_ready;
    logic [OUTWIDTH-1:0] m_data;
    logic                busy, err_frame;
    logic [15:0]         sample_cnt;

    logic                b_s_valid, b_s_ready, b_s_last;
    logic [WIDTH_A-1:0]  b_s_data;
    logic [IN_W-1:0]     b_clf_inp;
    logic [OUTWIDTH-1:0] b_clf_out;
    logic                b_m_valid, b_m_ready;
    logic [OUTWIDTH-1:0] b_m_data;
    logic                b_busy, b_err_frame;
    logic [15:0]         b_sample_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    // Stand-in for the external combinational classifier.
    function automatic logic [OUTWIDTH-1:0] clf_model(input logic [IN_W-1:0] v);
        return OUTWIDTH'(v) ^ OUTWIDTH'(v >> 14) ^ 22'h2A5A5;
    endfunction

    assign clf_out   = clf_model(clf_inp);
    assign b_clf_out = clf_model(b_clf_inp);

    classifier_seq_ctrl #(.NUM_A(NUM_A), .WIDTH_A(WIDTH_A), .OUTWIDTH(OUTWIDTH),
                          .SETTLE_CYCLES(SETTLE)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .s_last(s_last), .clf_inp(clf_inp), .clf_out(clf_out), .m_valid(m_valid),
        .m_ready(m_ready), .m_data(m_data), .busy(busy), .err_frame(err_frame),
        .sample_cnt(sample_cnt));

    classifier_seq_ctrl #(.NUM_A(NUM_A), .WIDTH_A(WIDTH_A), .OUTWIDTH(OUTWIDTH),
                          .SETTLE_CYCLES(1)) dut_s1 (
        .clk(clk), .rst(rst), .s_valid(b_s_valid), .s_ready(b_s_ready), .s_data(b_s_data),
        .s_last(b_s_last), .clf_inp(b_clf_inp), .clf_out(b_clf_out), .m_valid(b_m_valid),
        .m_ready(b_m_ready), .m_data(b_m_data), .busy(b_busy), .err_frame(b_err_frame),
        .sample_cnt(b_sample_cnt));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    endtask

    // Reference model: a sample is "pending" from its last accepted beat until the
    // result is taken; the result appears SETTLE+1 edges after that last beat.
    logic [IN_W-1:0]     md_feat;
    int                  md_idx;
    logic                md_pending, md_vld, md_err, md_ready;
    logic [OUTWIDTH-1:0] md_data;
    logic [15:0]         md_cnt;
    longint              md_n, md_due;
    logic                wrap_req = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            md_feat = '0; md_idx = 0; md_pending = 1'b0; md_vld = 1'b0; md_err = 1'b0;
            md_ready = 1'b0; md_data = '0; md_cnt = '0; md_n = 0; md_due = 0;
        end else begin
            md_n++;
            if (wrap_req) md_cnt = 16'hFFFF;
            if (md_vld && m_ready) begin
                md_vld = 1'b0; md_pending = 1'b0; md_cnt = md_cnt + 16'd1;
            end else if (md_pending && !md_vld && md_n == md_due) begin
                md_vld = 1'b1; md_data = clf_model(md_feat);
            end
            if (s_valid && md_ready) begin
                if (s_last && md_idx < NUM_A - 1) begin
                    md_err = 1'b1; md_idx = 0;
                end else begin
                    md_feat[md_idx*WIDTH_A +: WIDTH_A] = s_data;
                    if (md_idx == NUM_A - 1) begin
                        if (!s_last) md_err = 1'b1;
                        md_pending = 1'b1; md_due = md_n + SETTLE + 1; md_idx = 0;
                    end else begin
                        md_idx++;
                    end
                end
            end
            md_ready = !md_pending;
        end
    end

    always @(negedge clk) begin
        check("s_ready", 64'(s_ready), 64'(md_ready));
        check("m_valid", 64'(m_valid), 64'(md_vld));
        if (md_vld) check("m_data", 64'(m_data), 64'(md_data));
        check("clf_inp", 64'(clf_inp), 64'(md_feat));
        check("busy", 64'(busy), 64'(md_pending));
        check("err_frame", 64'(err_frame), 64'(md_err));
        if (!wrap_req) check("sample_cnt", 64'(sample_cnt), 64'(md_cnt));
    end

    task automatic do_reset(input int cyc);
        @(posedge clk); #2 rst = 1'b1;
        repeat (cyc) @(posedge clk);
        #2 rst = 1'b0;
    endtask

    // Returns just after the edge that accepted the beat.
    task automatic send_beat(input logic [WIDTH_A-1:0] d, input logic last);
        int  waited;
        logic ok;
        waited = 0; ok = 1'b0;
        @(negedge clk); s_valid = 1'b1; s_data = d; s_last = last;
        while (!ok) begin
            ok = s_ready;
            @(posedge clk);
            waited++;
            if (!ok && waited > 100) begin
                check("beat_accept_timeout", 64'(1), 64'(0));
                ok = 1'b1;
            end
        end
    endtask

    task automatic send_sample(input logic [IN_W-1:0] v, input logic last_ok);
        for (int k = 0; k < NUM_A; k++)
            send_beat(v[k*WIDTH_A +: WIDTH_A], (k == NUM_A - 1) ? last_ok : 1'b0);
        #1 s_valid = 1'b0; s_last = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (lat < 200) begin
            @(posedge clk); lat++; #1;
            if (m_valid) break;
        end
        if (lat >= 200) check("m_valid_timeout", 64'(1), 64'(0));
    endtask

    initial begin
        int               lat;
        logic             stable, saw;
        logic [IN_W-1:0]  v, c0;
        logic [OUTWIDTH-1:0] d0;

        s_valid = 1'b0; s_last = 1'b0; s_data = '0; m_ready = 1'b0;
        b_s_valid = 1'b0; b_s_last = 1'b0; b_s_data = '0; b_m_ready = 1'b1;
        rst = 1'b0;
        #1 rst = 1'b1;
        @(negedge clk);
        check("rst_s_ready", 64'(s_ready), 64'(0));
        check("rst_clf_inp", 64'(clf_inp), 64'(0));
        check("rst_cnt", 64'(sample_cnt), 64'(0));
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk); check("release_ready_low", 64'(s_ready), 64'(0));
        @(negedge clk); check("release_ready_high", 64'(s_ready), 64'(1));

        // Nominal sample 1..9
        m_ready = 1'b1;
        send_sample(36'h987654321, 1'b1);
        wait_valid(lat);
        check("nominal_latency", 64'(lat), 64'(5));
        check("nominal_clf_inp", 64'(clf_inp), 64'h987654321);
        check("nominal_m_data", 64'(m_data), 64'(clf_model(36'h987654321)));
        @(posedge clk); @(negedge clk);
        check("nominal_cnt", 64'(sample_cnt), 64'(1));
        check("nominal_ready_after", 64'(s_ready), 64'(1));

        // Backpressure in HOLD, with a stray beat offered meanwhile
        m_ready = 1'b0;
        v = {$urandom(), $urandom()} & 36'hFFFFFFFFF;
        send_sample(v, 1'b1);
        wait_valid(lat);
        check("bp_latency", 64'(lat), 64'(5));
        d0 = m_data; c0 = clf_inp; stable = 1'b1;
        s_valid = 1'b1; s_data = 4'hF;
        repeat (20) begin
            @(negedge clk);
            if (m_valid !== 1'b1 || m_data !== d0 || clf_inp !== c0 || s_ready !== 1'b0)
                stable = 1'b0;
        end
        check("bp_hold_stable", 64'(stable), 64'(1));
        check("bp_m_data", 64'(d0), 64'(clf_model(v)));
        s_valid = 1'b0; m_ready = 1'b1;
        check("bp_ready_in_hs_cycle", 64'(s_ready), 64'(0));
        @(posedge clk); @(negedge clk);
        check("bp_cnt", 64'(sample_cnt), 64'(2));
        check("bp_ready_after", 64'(s_ready), 64'(1));

        // Early s_last on beat 4, then a clean sample
        send_beat(4'h1, 1'b0); send_beat(4'h2, 1'b0); send_beat(4'h3, 1'b0);
        send_beat(4'h4, 1'b1);
        #1 s_valid = 1'b0; s_last = 1'b0;
        @(negedge clk);
        check("early_err", 64'(err_frame), 64'(1));
        check("early_stay_load", 64'(busy), 64'(0));
        send_sample(36'h123456789, 1'b1);
        wait_valid(lat);
        check("early_next_latency", 64'(lat), 64'(5));
        check("early_next_clf_inp", 64'(clf_inp), 64'h123456789);
        check("early_err_sticky", 64'(err_frame), 64'(1));
        @(posedge clk); @(negedge clk);
        check("early_cnt", 64'(sample_cnt), 64'(3));

        // Missing s_last on beat 9
        do_reset(2);
        @(negedge clk);
        check("reset_err_clear", 64'(err_frame), 64'(0));
        check("reset_cnt_clear", 64'(sample_cnt), 64'(0));
        v = 36'h0A5C3E1F7;
        send_sample(v, 1'b0);
        wait_valid(lat);
        check("nolast_latency", 64'(lat), 64'(5));
        check("nolast_err", 64'(err_frame), 64'(1));
        check("nolast_m_data", 64'(m_data), 64'(clf_model(v)));
        @(posedge clk); @(negedge clk);

        // Reset while settle counter is 2
        send_sample(36'h0F0F0F0F0, 1'b1);
        @(posedge clk); @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("midreset_m_valid", 64'(m_valid), 64'(0));
        check("midreset_busy", 64'(busy), 64'(0));
        check("midreset_clf_inp", 64'(clf_inp), 64'(0));
        check("midreset_m_data", 64'(m_data), 64'(0));
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;
        saw = 1'b0;
        repeat (15) begin @(negedge clk); if (m_valid) saw = 1'b1; end
        check("midreset_no_result", 64'(saw), 64'(0));
        send_sample(36'h987654321, 1'b1);
        wait_valid(lat);
        check("midreset_next_latency", 64'(lat), 64'(5));
        @(posedge clk); @(negedge clk);
        check("midreset_next_cnt", 64'(sample_cnt), 64'(1));

        // Counter wrap
        @(negedge clk);
        wrap_req = 1'b1;
        force dut.r_sample_cnt = 16'hFFFF;
        @(posedge clk); @(negedge clk);
        release dut.r_sample_cnt;
        wrap_req = 1'b0;
        @(negedge clk);
        check("wrap_preload", 64'(sample_cnt), 64'hFFFF);
        send_sample(36'h111111111, 1'b1);
        wait_valid(lat);
        @(posedge clk); @(negedge clk);
        check("wrap_to_zero", 64'(sample_cnt), 64'(0));

        // SETTLE_CYCLES=1 instance: result two edges after the last beat
        for (int k = 0; k < NUM_A; k++) begin
            int w;
            @(negedge clk);
            b_s_valid = 1'b1; b_s_data = 4'(k + 1); b_s_last = (k == NUM_A - 1);
            w = 0;
            while (!b_s_ready && w < 100) begin @(negedge clk); w++; end
            if (w >= 100) check("s1_accept_timeout", 64'(1), 64'(0));
            @(posedge clk);
        end
        #1 b_s_valid = 1'b0; b_s_last = 1'b0;
        lat = 0;
        while (lat < 50) begin
            @(posedge clk); lat++; #1;
            if (b_m_valid) break;
        end
        check("s1_latency", 64'(lat), 64'(2));
        check("s1_m_data", 64'(b_m_data), 64'(clf_model(36'h987654321)));
        @(posedge clk); @(negedge clk);
        check("s1_cnt", 64'(b_sample_cnt), 64'(1));

        // Random traffic with occasional framing errors and resets
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (i == 1500 || i == 3000) begin
                s_valid = 1'b0;
                do_reset(1 + (i / 1500));
            end else begin
                s_valid = ($urandom_range(0, 3) != 0);
                s_data  = 4'($urandom());
                s_last  = (md_idx == NUM_A - 1) ^ ($urandom_range(0, 19) == 0);
                m_ready = ($urandom_range(0, 2) != 0);
            end
        end
        @(negedge clk); s_valid = 1'b0; m_ready = 1'b1;
        repeat (20) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
